// File: rtl/psram_reader.sv
`default_nettype none
// ============================================================================
//  Module      : psram_reader
//  Description : Serial read engine for an SPI PSRAM. Issues Read (0x03) or
//                Fast Read (0x0B, 8 dummy cells) with a 24-bit address, then
//                shifts in a burst of bytes and presents each one as a
//                single-cycle valid pulse. sclk is a registered sys_clk/2.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    FAST_READ       0: cmd 0x03, no dummy; 1: cmd 0x0B + 8 dummy sclk cycles
//    CE_HIGH_CYCLES  sys_clk cycles ce_n stays high before next accept (1..255)
//  Ports
//    sys_clk      in   system clock
//    sys_reset_n  in   asynchronous active-low reset
//    req          in   read request, accepted when busy=0
//    addr[23:0]   in   start address, latched at accept
//    len[7:0]     in   byte count, latched at accept (0 means 256)
//    busy         out  accept edge until CE-high guard time has expired
//    data_out[7:0]out  last received byte, held between valid pulses
//    data_valid   out  one-cycle pulse per received byte
//    done         out  one-cycle pulse on the edge ce_n returns high
//    ce_n         out  PSRAM chip enable, active low
//    sclk         out  PSRAM serial clock, SPI mode 0
//    si           out  PSRAM serial input (sio[0])
//    so           in   PSRAM serial output (sio[1])
// ============================================================================
module psram_reader #(
  parameter int unsigned FAST_READ      = 0,
  parameter int unsigned CE_HIGH_CYCLES = 4
) (
  input  logic        sys_clk,
  input  logic        sys_reset_n,
  input  logic        req,
  input  logic [23:0] addr,
  input  logic [7:0]  len,
  output logic        busy,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        done,
  output logic        ce_n,
  output logic        sclk,
  output logic        si,
  input  logic        so
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_CMD   = 3'd1;
  localparam logic [2:0] c_ST_ADDR  = 3'd2;
  localparam logic [2:0] c_ST_DUMMY = 3'd3;
  localparam logic [2:0] c_ST_DATA  = 3'd4;
  localparam logic [2:0] c_ST_GUARD = 3'd5;

  localparam logic [7:0] c_CMD        = (FAST_READ != 0) ? 8'h0B : 8'h03;
  // Guard counter runs from CE_HIGH_CYCLES-1 down to 0, one step per cycle.
  localparam logic [7:0] c_GUARD_LOAD = 8'(CE_HIGH_CYCLES - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0]  r_state;
  logic        r_busy;
  logic        r_ce_n;
  logic        r_sclk;
  logic        r_si;
  logic [7:0]  r_data_out;
  logic        r_data_valid;
  logic        r_done;
  logic [30:0] r_tx_sr;      // bits still to send after the one on si
  logic [6:0]  r_rx_sr;      // first seven bits of the byte being received
  logic [4:0]  r_bit_cnt;    // cells remaining in current field, minus one
  logic [8:0]  r_byte_cnt;   // bytes remaining, 256 when len was 0
  logic [7:0]  r_guard_cnt;

  logic        w_accept;
  logic [8:0]  w_byte_init;
  logic        w_last_cell;

  assign w_accept    = req && !r_busy;
  assign w_byte_init = (len == 8'd0) ? 9'd256 : {1'b0, len};
  assign w_last_cell = (r_bit_cnt == 5'd0);

  // --------------------------------------------------------------------------
  // Sequencer. Within an active state, r_sclk tells which phase comes next:
  // r_sclk=0 means the next edge raises sclk (and samples so in DATA);
  // r_sclk=1 means the next edge lowers sclk and advances si / the counters.
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_state      <= c_ST_IDLE;
      r_busy       <= 1'b0;
      r_ce_n       <= 1'b1;
      r_sclk       <= 1'b0;
      r_si         <= 1'b0;
      r_data_out   <= 8'h00;
      r_data_valid <= 1'b0;
      r_done       <= 1'b0;
      r_tx_sr      <= 31'd0;
      r_rx_sr      <= 7'd0;
      r_bit_cnt    <= 5'd0;
      r_byte_cnt   <= 9'd0;
      r_guard_cnt  <= 8'd0;
    end else begin
      r_data_valid <= 1'b0;
      r_done       <= 1'b0;

      case (r_state)
        c_ST_IDLE: begin
          r_ce_n <= 1'b1;
          r_sclk <= 1'b0;
          r_si   <= 1'b0;
          if (w_accept) begin
            r_busy     <= 1'b1;
            r_ce_n     <= 1'b0;
            r_si       <= c_CMD[7];
            r_tx_sr    <= {c_CMD[6:0], addr};
            r_bit_cnt  <= 5'd7;
            r_byte_cnt <= w_byte_init;
            r_state    <= c_ST_CMD;
          end
        end

        c_ST_CMD: begin
          if (!r_sclk) begin
            r_sclk <= 1'b1;
          end else begin
            r_sclk  <= 1'b0;
            // Address follows the command with no gap.
            r_si    <= r_tx_sr[30];
            r_tx_sr <= {r_tx_sr[29:0], 1'b0};
            if (w_last_cell) begin
              r_bit_cnt <= 5'd23;
              r_state   <= c_ST_ADDR;
            end else begin
              r_bit_cnt <= r_bit_cnt - 5'd1;
            end
          end
        end

        c_ST_ADDR: begin
          if (!r_sclk) begin
            r_sclk <= 1'b1;
          end else begin
            r_sclk <= 1'b0;
            if (w_last_cell) begin
              r_si      <= 1'b0;
              r_bit_cnt <= 5'd7;
              r_state   <= (FAST_READ != 0) ? c_ST_DUMMY : c_ST_DATA;
            end else begin
              r_si      <= r_tx_sr[30];
              r_tx_sr   <= {r_tx_sr[29:0], 1'b0};
              r_bit_cnt <= r_bit_cnt - 5'd1;
            end
          end
        end

        c_ST_DUMMY: begin
          // so is not sampled here; the device output is undefined.
          if (!r_sclk) begin
            r_sclk <= 1'b1;
          end else begin
            r_sclk <= 1'b0;
            r_si   <= 1'b0;
            if (w_last_cell) begin
              r_bit_cnt <= 5'd7;
              r_state   <= c_ST_DATA;
            end else begin
              r_bit_cnt <= r_bit_cnt - 5'd1;
            end
          end
        end

        c_ST_DATA: begin
          if (!r_sclk) begin
            r_sclk  <= 1'b1;
            r_rx_sr <= {r_rx_sr[5:0], so};
            if (w_last_cell) begin
              r_data_out   <= {r_rx_sr, so};
              r_data_valid <= 1'b1;
            end
          end else begin
            r_sclk <= 1'b0;
            r_si   <= 1'b0;
            if (w_last_cell) begin
              if (r_byte_cnt == 9'd1) begin
                // Last byte complete: release the device on this low edge.
                r_ce_n      <= 1'b1;
                r_done      <= 1'b1;
                r_byte_cnt  <= 9'd0;
                r_guard_cnt <= c_GUARD_LOAD;
                r_state     <= c_ST_GUARD;
              end else begin
                r_byte_cnt <= r_byte_cnt - 9'd1;
                r_bit_cnt  <= 5'd7;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt - 5'd1;
            end
          end
        end

        c_ST_GUARD: begin
          r_ce_n <= 1'b1;
          r_sclk <= 1'b0;
          r_si   <= 1'b0;
          // busy drops on the final guard edge; a req seen on that same edge
          // still finds r_busy=1 and is only taken on the following edge.
          if (r_guard_cnt == 8'd0) begin
            r_busy  <= 1'b0;
            r_state <= c_ST_IDLE;
          end else begin
            r_guard_cnt <= r_guard_cnt - 8'd1;
          end
        end

        default: begin
          r_state <= c_ST_IDLE;
          r_busy  <= 1'b0;
          r_ce_n  <= 1'b1;
          r_sclk  <= 1'b0;
          r_si    <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign done       = r_done;
  assign ce_n       = r_ce_n;
  assign sclk       = r_sclk;
  assign si         = r_si;

endmodule
`default_nettype wire

// File: tb/tb_psram_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psram_reader
//  Description : Directed bench for psram_reader. Instance A is a plain Read
//                (CE_HIGH_CYCLES=4), instance B a Fast Read (CE_HIGH_CYCLES=2).
//                A serial PSRAM model per instance serves bytes from mdata.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psram_reader;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  logic        rst_n;
  // instance A
  logic        req_a, busy_a, dv_a, done_a, ce_n_a, sclk_a, si_a, so_a;
  logic [23:0] addr_a;
  logic [7:0]  len_a, dout_a;
  // instance B
  logic        req_b, busy_b, dv_b, done_b, ce_n_b, sclk_b, si_b, so_b;
  logic [23:0] addr_b;
  logic [7:0]  len_b, dout_b;

  psram_reader #(.FAST_READ(0), .CE_HIGH_CYCLES(4)) dut_a (
    .sys_clk(sys_clk), .sys_reset_n(rst_n), .req(req_a), .addr(addr_a),
    .len(len_a), .busy(busy_a), .data_out(dout_a), .data_valid(dv_a),
    .done(done_a), .ce_n(ce_n_a), .sclk(sclk_a), .si(si_a), .so(so_a));

  psram_reader #(.FAST_READ(1), .CE_HIGH_CYCLES(2)) dut_b (
    .sys_clk(sys_clk), .sys_reset_n(rst_n), .req(req_b), .addr(addr_b),
    .len(len_b), .busy(busy_b), .data_out(dout_b), .data_valid(dv_b),
    .done(done_b), .ce_n(ce_n_b), .sclk(sclk_b), .si(si_b), .so(so_b));

  int total = 0;
  int bad   = 0;

  logic [7:0] mdata [0:255];

  // Device model: byte n of the data phase comes from mdata[n], MSB first.
  function automatic logic mbit(input int rises, input int dummy);
    int j;
    logic [7:0] b;
    j = rises - 32 - dummy;
    if (j < 0) return 1'b0;
    b = mdata[(j / 8) % 256];
    return b[7 - (j % 8)];
  endfunction

  // ---------------- monitor + model, instance A ----------------
  int acc_a [0:15];   int acc_n_a = 0;
  int dn_a  [0:15];   int dn_n_a  = 0;
  int dvc_a [0:511];  int dv_n_a  = 0;
  logic [7:0] dvd_a [0:511];
  int bfall_a = 0, rise_a = 0, viol = 0;
  logic [31:0] sisr_a = 0;
  logic pb_a = 0, pce_a = 1, psclk_a = 0;

  always @(negedge sys_clk) begin
    if (busy_a && !pb_a && acc_n_a < 16) begin acc_a[acc_n_a] = cyc; acc_n_a++; end
    if (!busy_a && pb_a) bfall_a = cyc;
    pb_a = busy_a;
    if (dv_a && dv_n_a < 512) begin dvd_a[dv_n_a] = dout_a; dvc_a[dv_n_a] = cyc; dv_n_a++; end
    if (done_a && dn_n_a < 16) begin dn_a[dn_n_a] = cyc; dn_n_a++; end
    if (ce_n_a !== pce_a && sclk_a !== 1'b0) viol++;
    if (!ce_n_a && pce_a) rise_a = 0;
    if (sclk_a && !psclk_a) begin
      if (ce_n_a) viol++;
      if (rise_a < 32) sisr_a = {sisr_a[30:0], si_a};
      rise_a++;
    end
    pce_a = ce_n_a; psclk_a = sclk_a;
    so_a = mbit(rise_a, 0);
  end

  // ---------------- monitor + model, instance B ----------------
  int acc_b = 0, dn_b = 0, dvc_b = 0, dv_n_b = 0, dn_n_b = 0, bfall_b = 0;
  int rise_b = 0, dmy_ones_b = 0;
  logic [7:0]  dvd_b = 0;
  logic [31:0] sisr_b = 0;
  logic pb_b = 0, pce_b = 1, psclk_b = 0;

  always @(negedge sys_clk) begin
    if (busy_b && !pb_b) acc_b = cyc;
    if (!busy_b && pb_b) bfall_b = cyc;
    pb_b = busy_b;
    if (dv_b) begin dvd_b = dout_b; dvc_b = cyc; dv_n_b++; end
    if (done_b) begin dn_b = cyc; dn_n_b++; end
    if (ce_n_b !== pce_b && sclk_b !== 1'b0) viol++;
    if (!ce_n_b && pce_b) begin rise_b = 0; dmy_ones_b = 0; end
    if (sclk_b && !psclk_b) begin
      if (ce_n_b) viol++;
      if (rise_b < 32) sisr_b = {sisr_b[30:0], si_b};
      else if (rise_b < 40 && si_b !== 1'b0) dmy_ones_b++;
      rise_b++;
    end
    pce_b = ce_n_b; psclk_b = sclk_b;
    so_b = mbit(rise_b, 8);
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic start_a(input logic [23:0] a, input logic [7:0] l);
    tick();
    addr_a = a; len_a = l; req_a = 1'b1;
    tick();
    req_a = 1'b0;
  endtask

  // Wait until a done beyond base has been seen and busy has dropped.
  task automatic wait_txn(input bit sel_b, input int base, input int lim, input string tag);
    int n;
    n = 0;
    while (n < lim && (sel_b ? (busy_b || dn_n_b == base) : (busy_a || dn_n_a == base))) begin
      tick();
      n++;
    end
    chk(tag, (n < lim) ? 32'd1 : 32'd0, 32'd1);
  endtask

  int e0, bacc, bdn, bdv, errs, n;

  initial begin
    rst_n = 1'b0;
    req_a = 0; addr_a = 0; len_a = 0;
    req_b = 0; addr_b = 0; len_b = 0;
    for (int i = 0; i < 256; i++) mdata[i] = 8'h00;
    repeat (3) tick();

    // ---- reset state ----
    chk("rst_ce_n",  {31'd0, ce_n_a}, 1);
    chk("rst_sclk",  {31'd0, sclk_a}, 0);
    chk("rst_si",    {31'd0, si_a}, 0);
    chk("rst_busy",  {31'd0, busy_a}, 0);
    chk("rst_dv",    {31'd0, dv_a}, 0);
    chk("rst_done",  {31'd0, done_a}, 0);
    chk("rst_dout",  {24'd0, dout_a}, 0);
    chk("rst_ce_n_b", {31'd0, ce_n_b}, 1);
    rst_n = 1'b1;
    tick();

    // ---- single read, len=1 ----
    mdata[0] = 8'hAB;
    bacc = acc_n_a; bdn = dn_n_a; bdv = dv_n_a;
    start_a(24'hFF00FF, 8'd1);
    wait_txn(0, bdn, 300, "t1_wait");
    e0 = acc_a[bacc];
    chk("t1_si",     sisr_a, 32'h03FF00FF);
    chk("t1_nbytes", dv_n_a - bdv, 1);
    chk("t1_data",   {24'd0, dvd_a[bdv]}, 32'hAB);
    chk("t1_dv_t",   dvc_a[bdv] - e0, 79);
    chk("t1_done_t", dn_a[bdn] - e0, 80);
    chk("t1_busy_t", bfall_a - e0, 84);

    // ---- burst len=4 ----
    mdata[0] = 8'h11; mdata[1] = 8'h22; mdata[2] = 8'h33; mdata[3] = 8'h44;
    bacc = acc_n_a; bdn = dn_n_a; bdv = dv_n_a;
    start_a(24'h000010, 8'd4);
    wait_txn(0, bdn, 400, "t2_wait");
    e0 = acc_a[bacc];
    chk("t2_si",     sisr_a, 32'h03000010);
    chk("t2_nbytes", dv_n_a - bdv, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_dv_t%0d", i), dvc_a[bdv + i] - e0, 79 + 16 * i);
      chk($sformatf("t2_data%0d", i), {24'd0, dvd_a[bdv + i]}, 32'h11 * (i + 1));
    end
    chk("t2_done_t", dn_a[bdn] - e0, 128);

    // ---- len=0 means 256 bytes ----
    for (int i = 0; i < 256; i++) mdata[i] = 8'(i);
    bacc = acc_n_a; bdn = dn_n_a; bdv = dv_n_a;
    start_a(24'hABCDEF, 8'd0);
    wait_txn(0, bdn, 5000, "t3_wait");
    e0 = acc_a[bacc];
    chk("t3_nbytes", dv_n_a - bdv, 256);
    errs = 0;
    for (int i = 0; i < 256; i++) if (dvd_a[bdv + i] !== 8'(i)) errs++;
    chk("t3_data_errs", errs, 0);
    chk("t3_last_dv_t", dvc_a[bdv + 255] - e0, 4159);
    chk("t3_done_t",    dn_a[bdn] - e0, 4160);

    // ---- fast read on instance B ----
    mdata[0] = 8'hC5;
    bdn = dn_n_b; bdv = dv_n_b;
    tick();
    addr_b = 24'h123456; len_b = 8'd1; req_b = 1'b1;
    tick();
    req_b = 1'b0;
    wait_txn(1, bdn, 300, "t4_wait");
    e0 = acc_b;
    chk("t4_si",       sisr_b, 32'h0B123456);
    chk("t4_dummy_si", dmy_ones_b, 0);
    chk("t4_nbytes",   dv_n_b - bdv, 1);
    chk("t4_data",     {24'd0, dvd_b}, 32'hC5);
    chk("t4_dv_t",     dvc_b - e0, 95);
    chk("t4_done_t",   dn_b - e0, 96);
    chk("t4_busy_t",   bfall_b - e0, 98);

    // ---- req held high: back-to-back accepts ----
    mdata[0] = 8'h96;
    bacc = acc_n_a; bdn = dn_n_a;
    tick();
    addr_a = 24'h000100; len_a = 8'd1; req_a = 1'b1;
    n = 0;
    while (acc_n_a < bacc + 3 && n < 600) begin tick(); n++; end
    req_a = 1'b0;
    chk("t5_accepts_seen", (n < 600) ? 32'd1 : 32'd0, 1);
    wait_txn(0, bdn + 2, 300, "t5_wait");
    chk("t5_naccepts", acc_n_a - bacc, 3);
    chk("t5_gap0", acc_a[bacc + 1] - dn_a[bdn], 5);
    chk("t5_gap1", acc_a[bacc + 2] - dn_a[bdn + 1], 5);

    // ---- req pulsed while busy is ignored ----
    bacc = acc_n_a; bdn = dn_n_a;
    start_a(24'h000200, 8'd1);
    repeat (20) tick();
    req_a = 1'b1;
    tick();
    req_a = 1'b0;
    wait_txn(0, bdn, 300, "t6_wait");
    repeat (40) tick();
    chk("t6_naccepts", acc_n_a - bacc, 1);
    chk("t6_ndone",    dn_n_a - bdn, 1);

    // ---- reset mid-transaction at E0+40 ----
    mdata[0] = 8'h77;
    bacc = acc_n_a; bdn = dn_n_a; bdv = dv_n_a;
    start_a(24'h00F000, 8'd1);
    e0 = acc_a[bacc];
    n = 0;
    while (cyc < e0 + 40 && n < 100) begin tick(); n++; end
    chk("t7_reached", cyc, e0 + 40);
    chk("t7_ce_active", {31'd0, ce_n_a}, 0);
    rst_n = 1'b0;
    #1;
    chk("t7_ce_async",   {31'd0, ce_n_a}, 1);
    chk("t7_sclk_async", {31'd0, sclk_a}, 0);
    chk("t7_busy_async", {31'd0, busy_a}, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (100) tick();
    chk("t7_no_dv",   dv_n_a - bdv, 0);
    chk("t7_no_done", dn_n_a - bdn, 0);

    mdata[0] = 8'h5A;
    bacc = acc_n_a; bdn = dn_n_a; bdv = dv_n_a;
    start_a(24'h000001, 8'd1);
    wait_txn(0, bdn, 300, "t8_wait");
    e0 = acc_a[bacc];
    chk("t8_si",     sisr_a, 32'h03000001);
    chk("t8_data",   {24'd0, dvd_a[bdv]}, 32'h5A);
    chk("t8_dv_t",   dvc_a[bdv] - e0, 79);
    chk("t8_done_t", dn_a[bdn] - e0, 80);

    chk("sclk_vs_ce", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/psram_reader.md
# psram_reader

Serial read engine for the SPI PSRAM, complementing the existing write/reset sequencer. On request it issues a Read (0x03) or Fast Read (0x0B) command with a 24-bit address, then clocks in a burst of bytes on the device's serial output and presents each byte as a one-cycle valid pulse. It sits between the user-side request logic and the PSRAM pins (ce_n, clk, sio[0] out, sio[1] in). Everything runs in the sys_clk domain, and the serial clock is generated as a registered sys_clk/2.

## Interface
- FAST_READ, default 0: 0 selects command 0x03 with no dummy cycles; 1 selects 0x0B with 8 dummy sclk cycles after the address.
- CE_HIGH_CYCLES, default 4: minimum number of sys_clk cycles ce_n stays high after a transaction before the next request is accepted. Legal range is 1..255.
- sys_clk  in  1  system clock. Single clock for the block.
- sys_reset_n  in  1  asynchronous, active-low reset.
- req  in  1  read request. Accepted on a rising sys_clk edge where req=1 and busy=0.
- addr  in  24  start address, latched at accept.
- len  in  8  byte count, latched at accept. Values 1..255 give that many bytes; 0 means 256.
- busy  out  1  high from the accept edge until the CE-high guard time has expired.
- data_out  out  8  received byte, MSB first on the wire. Held between valid pulses.
- data_valid  out  1  one-cycle pulse per received byte. There is no backpressure.
- done  out  1  one-cycle pulse on the edge where ce_n returns high.
- ce_n  out  1  PSRAM chip enable, active low.
- sclk  out  1  PSRAM serial clock, registered, SPI mode 0.
- si  out  1  PSRAM serial input (sio[0]).
- so  in  1  PSRAM serial output (sio[1]).

## Operation
- States: IDLE, CMD, ADDR, DUMMY (only when FAST_READ=1), DATA, GUARD.
- Reset values (asynchronous): ce_n=1, sclk=0, si=0, busy=0, data_valid=0, done=0, data_out=0x00, all counters 0, state IDLE.
- IDLE:
  - ce_n=1, sclk=0, si=0.
  - When req=1, the block latches addr and len, sets busy=1 and ce_n=0, drives si=cmd[7], and goes to CMD.
- Bit cell: each sclk period is 2 sys_clk cycles.
  - Low phase: sclk=0 and si updates.
  - High phase: sclk=1. On DATA high phases, so is shifted into the byte register.
- CMD and ADDR:
  - 8 command bits, then addr[23:0], all MSB first.
  - 32 bit cells in total, with no gap between command and address.
- DUMMY:
  - 8 bit cells with si=0.
  - so is ignored.
- DATA:
  - si is held at 0.
  - On the high-phase edge that captures bit 0 (the 8th bit) of a byte, the block loads data_out with the full byte and pulses data_valid for one cycle.
  - The byte counter decrements. A latched len of 0 is treated as 256.
- End of transaction:
  - On the low-phase edge after the last byte's 8th sample, the block sets ce_n=1 and sclk=0 and pulses done.
  - It then enters GUARD.
- GUARD:
  - Counts CE_HIGH_CYCLES cycles with ce_n=1.
  - Then it clears busy and returns to IDLE.
- req while busy=1 is ignored and is not queued.
- req=1 on the same edge that busy falls is not accepted. It is accepted on the next edge if it is still high.
- Reset mid-transaction: ce_n goes to 1 immediately (asynchronously). No done pulse and no partial byte are emitted. The block resumes in IDLE.
- sclk never rises while ce_n=1, and sclk is always 0 on every ce_n transition.

## Timing
- E0 is the accept edge. D = 0 when FAST_READ=0, D = 16 when FAST_READ=1.
- Command/address bit k (k = 0..31): si valid from edge E0+2k; sclk high from edge E0+2k+1.
- Data bit j: sampled at edge E0+65+D+2j.
- Byte n (n = 0..len-1): data_valid at edge E0+79+D+16n.
- done pulse and ce_n↑: at edge E0+64+D+16·len.
- busy↓: at edge E0+64+D+16·len+CE_HIGH_CYCLES.
- Next accept is possible on the edge after busy↓.
- Example, len=1 and FAST_READ=0: data_valid at E0+79, done at E0+80, busy low at E0+84.

## Test plan
- Single read, FAST_READ=0: addr=0xFF00FF, len=1, device model returns 0xAB.
  - si shows 0x03,0xFF,0x00,0xFF MSB first.
  - data_out=0xAB with data_valid at E0+79.
  - done and ce_n↑ at E0+80; busy↓ at E0+84.
- Burst read: len=4, model returns 0x11,0x22,0x33,0x44.
  - Four data_valid pulses at E0+79, +95, +111, +127, with data matching in order.
  - done at E0+128.
- len=0: model returns an incrementing pattern.
  - Exactly 256 data_valid pulses.
  - done at E0+4160.
- FAST_READ=1, len=1:
  - Command 0x0B, then 16 cycles of dummy with si=0.
  - data_valid at E0+95.
- Handshake:
  - req held high continuously: accepts are exactly CE_HIGH_CYCLES+1 cycles after each done.
  - req pulsed while busy: ignored, and no extra transaction occurs.
- Reset asserted at E0+40:
  - ce_n=1 and sclk=0 asynchronously.
  - No data_valid or done pulse.
  - A new req after reset completes normally.
